arm_instr_encoder: RTL and testbench

- Streaming ARM instruction encoder and instruction-memory loader. It is the write-side counterpart to the pipeline's instruction decoder.
- Accepts field-level instruction requests (op, funct, cond, Rn, Rd, Src2 or branch target) over a valid/ready handshake.
- Packs each request into a 32-bit ARM word and buffers it in a small FIFO.
- Writes words to sequential imem addresses through a backpressured write port.
- Used by self-test and boot logic to assemble programs into imem before releasing the core.

---
 rtl/arm_enc_pkg.sv | 41 ++++
 rtl/enc_word_fifo.sv | 74 +++++++
 rtl/arm_instr_encoder.sv | 140 ++++++++++++++
 tb/tb_arm_instr_encoder.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_enc_pkg.sv
// arm_enc_pkg: shared definitions for the ARM instruction encoder.
//   - op field constants (DP, memory, branch, illegal)
//   - load-session state enum
//   - PC_AHEAD: ARM reads PC as the instruction address plus 8
//   - encode_word: packs request fields into a 32-bit ARM word
package arm_enc_pkg;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  localparam int unsigned PC_AHEAD = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    DRAIN = 2'b10,
    DONE  = 2'b11
  } state_t;

  // Branches carry only the link bit (funct[4]) plus a word offset.
  // Every other op is a straight field concatenation.
  function automatic logic [31:0] encode_word(
    input logic [1:0]  op,
    input logic [5:0]  funct,
    input logic [3:0]  cond,
    input logic [3:0]  rn,
    input logic [3:0]  rd,
    input logic [11:0] src2,
    input logic [23:0] imm24
  );
    logic [31:0] word;
    case (op)
      OP_BR:   word = {cond, OP_BR, funct[5:4], imm24};
      default: word = {cond, op, funct, rn, rd, src2};
    endcase
    return word;
  endfunction

endpackage

// File: rtl/enc_word_fifo.sv
// enc_word_fifo: DEPTH x 32 synchronous FIFO with registered full/empty.
// Ports:
//   clk, reset   clock, synchronous active-high reset (discards contents)
//   push, din    write a word (ignored while full)
//   pop, dout    dout shows the head word; pop removes it (ignored while empty)
//   full, empty  registered status flags
module enc_word_fifo #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic [31:0] din,
  input  logic        pop,
  output logic [31:0] dout,
  output logic        full,
  output logic        empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);
  localparam logic [PW:0]   CNT_ZERO = (PW+1)'(0);

  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic [PW:0]   count_next;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Occupancy after this cycle's push/pop.
  always_comb begin
    count_next = count;
    if (do_push && !do_pop) begin
      count_next = count + CNT_ONE;
    end else if (!do_push && do_pop) begin
      count_next = count - CNT_ONE;
    end else begin
      count_next = count;
    end
  end

  // Storage array; contents need no reset since empty gates every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers, count and flags; flags are registered from count_next.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= CNT_ZERO;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      count <= count_next;
      full  <= (count_next == CNT_FULL);
      empty <= (count_next == CNT_ZERO);
    end
  end

endmodule

// File: rtl/arm_instr_encoder.sv
// arm_instr_encoder: streams field-level instruction requests into ARM words
// and writes them to consecutive imem byte addresses.
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   start, finish                session begin (IDLE only) / end-of-requests pulses
//   req_valid/req_ready          request handshake
//   req_op..req_target           request fields (op, funct, cond, rn, rd, src2, branch target)
//   wr_en/wr_ready               imem write handshake
//   wr_addr, wr_data             write byte address and encoded word
//   done                         one-cycle pulse when the session completes
//   err                          sticky dropped-request flag, cleared by start
//   word_count                   words written this session
module arm_instr_encoder
  import arm_enc_pkg::*;
#(
  parameter int              ADDR_W    = 16,
  parameter int              DEPTH     = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR = {ADDR_W{1'b0}}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              finish,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [5:0]        req_funct,
  input  logic [3:0]        req_cond,
  input  logic [3:0]        req_rn,
  input  logic [3:0]        req_rd,
  input  logic [11:0]       req_src2,
  input  logic [ADDR_W-1:0] req_target,
  output logic              wr_en,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] word_count
);

  localparam logic [ADDR_W-1:0] WORD_BYTES = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] PC_OFF     = ADDR_W'(PC_AHEAD);
  localparam logic [ADDR_W-1:0] CNT_ONE    = ADDR_W'(1);

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] enq_pc;
  logic [ADDR_W-1:0] br_off;
  logic [61:0]       off_words;
  logic              br_ovf;
  logic              br_misaligned;
  logic              drop;
  logic              accept;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [31:0]       enc_word;
  logic [31:0]       fifo_dout;

  // Byte offset from the branch's PC view; off_words is the sign-extended
  // word offset (byte offset >> 2), wide enough for any ADDR_W below 64.
  assign br_off    = req_target - (enq_pc + PC_OFF);
  assign off_words = {{(64-ADDR_W){br_off[ADDR_W-1]}}, br_off[ADDR_W-1:2]};
  // enq_pc is always word aligned, so the offset's low bits are the target's.
  assign br_misaligned = (br_off[1:0] != 2'b00);
  // Offset must be representable in 24 signed bits.
  assign br_ovf = (off_words[61:23] != {39{off_words[23]}});

  assign drop = (req_op == OP_ILL) ||
                ((req_op == OP_BR) && (br_misaligned || br_ovf));

  // Ready uses the registered full flag only, never a same-cycle pop.
  assign req_ready = (state == RUN) && !fifo_full;
  assign accept    = req_valid && req_ready;
  assign push      = accept && !drop;
  assign wr_en     = !fifo_empty;
  assign pop       = wr_en && wr_ready;
  assign wr_data   = fifo_dout;
  assign done      = (state == DONE);

  assign enc_word = encode_word(req_op, req_funct, req_cond, req_rn, req_rd,
                                req_src2, off_words[23:0]);

  enc_word_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (enc_word),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Session state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Session sequencing; DRAIN waits for the FIFO (and so the last write) to empty.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start)      state_next = RUN;   else state_next = IDLE;
      RUN:     if (finish)     state_next = DRAIN; else state_next = RUN;
      DRAIN:   if (fifo_empty) state_next = DONE;  else state_next = DRAIN;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Address counters, word counter and sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      enq_pc     <= BASE_ADDR;
      wr_addr    <= BASE_ADDR;
      err        <= 1'b0;
      word_count <= {ADDR_W{1'b0}};
    end else if ((state == IDLE) && start) begin
      enq_pc     <= BASE_ADDR;
      wr_addr    <= BASE_ADDR;
      err        <= 1'b0;
      word_count <= {ADDR_W{1'b0}};
    end else begin
      if (push)          enq_pc <= enq_pc + WORD_BYTES;
      if (accept && drop) err   <= 1'b1;
      if (pop) begin
        wr_addr    <= wr_addr + WORD_BYTES;
        word_count <= word_count + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_arm_instr_encoder.sv
// Self-checking bench for arm_instr_encoder: expected writes are queued when
// requests are accepted and compared as the DUT writes imem. A second
// instance (ADDR_W=8, BASE_ADDR=0xF8) shares the stimulus to cover wrap.
module tb_arm_instr_encoder;
  import arm_enc_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, finish, req_valid, wr_ready;
  logic [1:0]  req_op;
  logic [5:0]  req_funct;
  logic [3:0]  req_cond, req_rn, req_rd;
  logic [11:0] req_src2;
  logic [15:0] req_target;
  logic        req_ready, wr_en, done, err;
  logic [15:0] wr_addr, word_count;
  logic [31:0] wr_data;
  logic        b_req_ready, b_wr_en, b_done, b_err;
  logic [7:0]  b_wr_addr, b_word_count;
  logic [31:0] b_wr_data;

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        b_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          acc_cnt = 0;
  logic [15:0] model_addr = 16'h0000;
  logic [15:0] b_model_addr = 16'h00F8;
  logic        b_en = 1'b0;

  always #5 clk = ~clk;

  arm_instr_encoder #(.ADDR_W(16), .DEPTH(4), .BASE_ADDR(16'h0000)) dut (
    .clk(clk), .reset(reset), .start(start), .finish(finish),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_funct(req_funct), .req_cond(req_cond), .req_rn(req_rn),
    .req_rd(req_rd), .req_src2(req_src2), .req_target(req_target),
    .wr_en(wr_en), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .done(done), .err(err), .word_count(word_count)
  );

  arm_instr_encoder #(.ADDR_W(8), .DEPTH(4), .BASE_ADDR(8'hF8)) dut_wrap (
    .clk(clk), .reset(reset), .start(start), .finish(finish),
    .req_valid(req_valid), .req_ready(b_req_ready), .req_op(req_op),
    .req_funct(req_funct), .req_cond(req_cond), .req_rn(req_rn),
    .req_rd(req_rd), .req_src2(req_src2), .req_target(req_target[7:0]),
    .wr_en(b_wr_en), .wr_ready(wr_ready), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .done(b_done), .err(b_err), .word_count(b_word_count)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Scoreboard for the main instance: every write, and every stalled cycle, is
  // checked against the head of the expected queue.
  always @(negedge clk) begin
    if (!reset && wr_en) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_write", {63'd0, wr_en}, 64'd0);
      end else if (wr_ready) begin
        exp_t e;
        e = exp_q.pop_front();
        check_eq("wr_addr", wr_addr, e.addr);
        check_eq("wr_data", wr_data, e.data);
      end else begin
        check_eq("stall_addr", wr_addr, exp_q[0].addr);
        check_eq("stall_data", wr_data, exp_q[0].data);
      end
    end
  end

  // Scoreboard for the wrap instance, active only in the wrap session.
  always @(negedge clk) begin
    if (!reset && b_en && b_wr_en && wr_ready) begin
      if (b_q.size() == 0) begin
        check_eq("wrap_spurious_write", {63'd0, b_wr_en}, 64'd0);
      end else begin
        exp_t e;
        e = b_q.pop_front();
        check_eq("wrap_wr_addr", {8'd0, b_wr_addr}, e.addr);
        check_eq("wrap_wr_data", b_wr_data, e.data);
      end
    end
  end

  // Accepted handshakes, sampled mid-cycle ahead of the accepting edge.
  always @(negedge clk) begin
    if (req_valid && req_ready) acc_cnt++;
  end

  // All drive tasks start and end at posedge+1.
  task automatic send_req(input logic [1:0] op, input logic [5:0] funct,
                          input logic [3:0] rn, input logic [3:0] rd,
                          input logic [11:0] src2, input logic [15:0] target,
                          input logic exp_drop, input logic [31:0] exp_word);
    logic ok;
    ok = 1'b0;
    req_op = op; req_funct = funct; req_cond = 4'hE; req_rn = rn; req_rd = rd;
    req_src2 = src2; req_target = target; req_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_eq("req_accept_timeout", {63'd0, req_ready}, 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (ok && !exp_drop) begin
      exp_q.push_back('{model_addr, exp_word});
      model_addr += 16'd4;
      if (b_en) begin
        b_q.push_back('{b_model_addr, exp_word});
        b_model_addr = (b_model_addr + 16'd4) & 16'h00FF;
      end
    end
  endtask

  task automatic start_session();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    model_addr = 16'h0000;
    b_model_addr = 16'h00F8;
  endtask

  task automatic finish_session(input int exp_cnt, input logic exp_err);
    finish = 1'b1;
    @(posedge clk); #1;
    finish = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (done) break;
    end
    check_eq("done_pulse", {63'd0, done}, 64'd1);
    check_eq("word_count", word_count, exp_cnt);
    check_eq("err_at_done", {63'd0, err}, {63'd0, exp_err});
    check_eq("queue_drained", exp_q.size(), 64'd0);
    @(negedge clk);
    check_eq("done_one_cycle", {63'd0, done}, 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    reset = 1'b1; start = 1'b0; finish = 1'b0; req_valid = 1'b0; wr_ready = 1'b1;
    req_op = OP_DP; req_funct = 6'd0; req_cond = 4'hE; req_rn = 4'd0;
    req_rd = 4'd0; req_src2 = 12'd0; req_target = 16'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    check_eq("rst_req_ready", {63'd0, req_ready}, 64'd0);
    check_eq("rst_wr_en", {63'd0, wr_en}, 64'd0);
    check_eq("rst_done", {63'd0, done}, 64'd0);
    check_eq("rst_err", {63'd0, err}, 64'd0);
    check_eq("rst_word_count", word_count, 64'd0);
    check_eq("rst_wr_addr", wr_addr, 64'h0);
    check_eq("rst_wrap_wr_addr", b_wr_addr, 64'hF8);
    check_eq("rst_wrap_done", {63'd0, b_done}, 64'd0);
    @(posedge clk); #1;

    // ADD R1,R2,#5
    start_session();
    send_req(OP_DP, 6'b101000, 4'd2, 4'd1, 12'h005, 16'h0, 1'b0, 32'hE2821005);
    finish_session(1, 1'b0);

    // LDR, NOP, B back to 0
    start_session();
    send_req(OP_MEM, 6'b011001, 4'd0, 4'd3, 12'h008, 16'h0, 1'b0, 32'hE5903008);
    send_req(OP_DP, 6'b011010, 4'd0, 4'd0, 12'h000, 16'h0, 1'b0, 32'hE1A00000);
    send_req(OP_BR, 6'b100000, 4'd0, 4'd0, 12'h000, 16'h0, 1'b0, 32'hEAFFFFFC);
    finish_session(3, 1'b0);

    // BL back to 0 at 0x8, then a forward B at 0xC to 0x20
    start_session();
    send_req(OP_DP, 6'b011010, 4'd0, 4'd0, 12'h000, 16'h0, 1'b0, 32'hE1A00000);
    send_req(OP_DP, 6'b011010, 4'd0, 4'd0, 12'h000, 16'h0, 1'b0, 32'hE1A00000);
    send_req(OP_BR, 6'b110000, 4'd0, 4'd0, 12'h000, 16'h0, 1'b0, 32'hEBFFFFFC);
    send_req(OP_BR, 6'b100000, 4'd0, 4'd0, 12'h000, 16'h20, 1'b0, 32'hEA000003);
    finish_session(4, 1'b0);

    // Backpressure: 6 requests against a stalled write port
    start_session();
    wr_ready = 1'b0;
    acc_cnt = 0;
    fork
      begin
        for (int i = 0; i < 6; i++)
          send_req(OP_DP, 6'b101000, 4'd2, 4'd1, 12'(i), 16'h0, 1'b0,
                   32'hE2821000 | 32'(i));
      end
      begin
        repeat (9) @(posedge clk);
        @(negedge clk);
        check_eq("bp_req_ready_low", {63'd0, req_ready}, 64'd0);
        check_eq("bp_wr_en_high", {63'd0, wr_en}, 64'd1);
        check_eq("bp_accepts_when_full", acc_cnt, 64'd4);
        @(posedge clk); #1;
        wr_ready = 1'b1;
      end
    join
    finish_session(6, 1'b0);

    // Illegal op and misaligned branch are consumed, dropped and flagged
    start_session();
    send_req(OP_ILL, 6'b000000, 4'd0, 4'd0, 12'h000, 16'h0, 1'b1, 32'h0);
    send_req(OP_BR, 6'b100000, 4'd0, 4'd0, 12'h000, 16'h6, 1'b1, 32'h0);
    @(negedge clk);
    check_eq("err_after_drop", {63'd0, err}, 64'd1);
    @(posedge clk); #1;
    send_req(OP_DP, 6'b101000, 4'd2, 4'd1, 12'h005, 16'h0, 1'b0, 32'hE2821005);
    finish_session(1, 1'b1);

    // Wrap on the 8-bit instance; start also clears err
    b_en = 1'b1;
    start_session();
    @(negedge clk);
    check_eq("err_cleared_by_start", {63'd0, err}, 64'd0);
    check_eq("wrap_req_ready", {63'd0, b_req_ready}, 64'd1);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++)
      send_req(OP_DP, 6'b101000, 4'd2, 4'd1, 12'(i + 8), 16'h0, 1'b0,
               32'hE2821000 | 32'(i + 8));
    finish_session(4, 1'b0);
    check_eq("wrap_word_count", b_word_count, 64'd4);
    check_eq("wrap_err", {63'd0, b_err}, 64'd0);
    check_eq("wrap_queue_drained", b_q.size(), 64'd0);
    b_en = 1'b0;

    // Reset while draining with 3 words stuck behind wr_ready=0
    start_session();
    wr_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      send_req(OP_DP, 6'b101000, 4'd2, 4'd1, 12'(i), 16'h0, 1'b0,
               32'hE2821000 | 32'(i));
    finish = 1'b1;
    @(posedge clk); #1;
    finish = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    @(negedge clk);
    check_eq("mid_rst_wr_en", {63'd0, wr_en}, 64'd0);
    check_eq("mid_rst_req_ready", {63'd0, req_ready}, 64'd0);
    check_eq("mid_rst_done", {63'd0, done}, 64'd0);
    check_eq("mid_rst_word_count", word_count, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    wr_ready = 1'b1;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (done || wr_en || req_ready) seen++;
    end
    check_eq("idle_after_reset", seen, 64'd0);
    @(posedge clk); #1;
    start_session();
    send_req(OP_DP, 6'b101000, 4'd2, 4'd1, 12'h005, 16'h0, 1'b0, 32'hE2821005);
    finish_session(1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
